// File: rtl/kalman_pkg.sv
// Constants shared by the telemetry frame transmitter and receiver.
// Frame layout: HDR0, HDR1, then roll/pitch/yaw as big-endian 16-bit words.
package kalman_pkg;

   localparam logic [7:0] FRAME_HDR0          = 8'hDE;
   localparam logic [7:0] FRAME_HDR1          = 8'hAD;
   localparam int         FRAME_PAYLOAD_BYTES = 6;
   localparam int         DEFAULT_BAUD_DIV    = 1041;

   localparam logic [1:0] FR_HUNT_DE  = 2'd0;
   localparam logic [1:0] FR_HUNT_AD  = 2'd1;
   localparam logic [1:0] FR_PAYLOAD  = 2'd2;

   function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: rx synchroniser, start/data/stop bit FSM, byte strobe and
// stop-bit error strobe. BAUD_DIV must be at least 4.
module uart_rx #(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       stop_err,
   output logic       bit_idle
);

   localparam int            CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          rx_meta_reg;
   logic          rx_sync_reg;
   logic          rx_prev_reg;
   logic [1:0]    state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    shift_reg;
   logic [7:0]    byte_data_reg;
   logic          byte_valid_reg;
   logic          stop_err_reg;

   assign byte_data  = byte_data_reg;
   assign byte_valid = byte_valid_reg;
   assign stop_err   = stop_err_reg;
   assign bit_idle   = (state_reg == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_reg    <= 1'b1;
         rx_sync_reg    <= 1'b1;
         rx_prev_reg    <= 1'b1;
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         byte_data_reg  <= '0;
         byte_valid_reg <= 1'b0;
         stop_err_reg   <= 1'b0;
      end else begin
         rx_meta_reg    <= rx;
         rx_sync_reg    <= rx_meta_reg;
         rx_prev_reg    <= rx_sync_reg;
         byte_valid_reg <= 1'b0;
         stop_err_reg   <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               // Edge detect also covers re-arming after a bad stop bit: the
               // line must be seen high again before a new start is accepted.
               if (rx_prev_reg && !rx_sync_reg) begin
                  state_reg <= S_START;
                  cnt_reg   <= '0;
               end
            end
            S_START: begin
               if (cnt_reg == CNT_HALF) begin
                  cnt_reg     <= '0;
                  bit_idx_reg <= '0;
                  state_reg   <= rx_sync_reg ? S_IDLE : S_DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg     <= '0;
                  shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                  bit_idx_reg <= bit_idx_reg + 1'b1;
                  if (bit_idx_reg == 3'd7) state_reg <= S_STOP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= S_IDLE;
                  if (rx_sync_reg) begin
                     byte_data_reg  <= shift_reg;
                     byte_valid_reg <= 1'b1;
                  end else begin
                     stop_err_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Telemetry frame receiver: hunts the DE AD header, collects six payload bytes
// and publishes roll/pitch/yaw together; aborts on stop-bit errors or idle timeout.
module uart_frame_rx
   import kalman_pkg::*;
#(
   parameter int BAUD_DIV     = DEFAULT_BAUD_DIV,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic [15:0] roll,
   output logic [15:0] pitch,
   output logic [15:0] yaw,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam int            TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
   localparam int            TW       = $clog2(TO_LIMIT + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_LIMIT - 1);
   localparam logic [2:0]    LAST_IDX = 3'(FRAME_PAYLOAD_BYTES - 1);

   logic       rx_valid;
   logic       rx_err;
   logic       rx_idle;
   logic [7:0] rx_byte;

   uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_data  (rx_byte),
      .byte_valid (rx_valid),
      .stop_err   (rx_err),
      .bit_idle   (rx_idle)
   );

   logic [1:0]    fstate_reg;
   logic [2:0]    idx_reg;
   logic [TW-1:0] idle_cnt_reg;
   logic          timeout_reg;
   logic          frame_valid_reg;
   logic [15:0]   roll_reg;
   logic [15:0]   pitch_reg;
   logic [15:0]   yaw_reg;
   logic [7:0]    shadow_reg  [FRAME_PAYLOAD_BYTES];
   logic [7:0]    shadow_next [FRAME_PAYLOAD_BYTES];

   logic in_frame;
   logic pay_byte;
   logic timeout_hit;

   assign in_frame    = (fstate_reg != FR_HUNT_DE);
   assign pay_byte    = rx_valid && (fstate_reg == FR_PAYLOAD);
   assign timeout_hit = in_frame && rx_idle && !rx_valid && (idle_cnt_reg == TO_LAST);

   assign byte_data   = rx_byte;
   assign byte_valid  = rx_valid;
   assign frame_valid = frame_valid_reg;
   assign frame_err   = rx_err | timeout_reg;
   assign roll        = roll_reg;
   assign pitch       = pitch_reg;
   assign yaw         = yaw_reg;

   // The last payload byte is forwarded straight into the angle load so all
   // three angles update in the cycle after its strobe.
   generate
      for (genvar gi = 0; gi < FRAME_PAYLOAD_BYTES; gi++) begin : g_shadow
         assign shadow_next[gi] = (pay_byte && idx_reg == 3'(gi)) ? rx_byte : shadow_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FRAME_PAYLOAD_BYTES; i++) shadow_reg[i] <= '0;
      end else begin
         for (int i = 0; i < FRAME_PAYLOAD_BYTES; i++) shadow_reg[i] <= shadow_next[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fstate_reg      <= FR_HUNT_DE;
         idx_reg         <= '0;
         idle_cnt_reg    <= '0;
         timeout_reg     <= 1'b0;
         frame_valid_reg <= 1'b0;
         roll_reg        <= '0;
         pitch_reg       <= '0;
         yaw_reg         <= '0;
      end else begin
         frame_valid_reg <= 1'b0;
         timeout_reg     <= 1'b0;
         if (rx_err) begin
            fstate_reg   <= FR_HUNT_DE;
            idle_cnt_reg <= '0;
         end else if (timeout_hit) begin
            fstate_reg   <= FR_HUNT_DE;
            timeout_reg  <= 1'b1;
            idle_cnt_reg <= '0;
         end else begin
            if (rx_valid || !in_frame) idle_cnt_reg <= '0;
            else if (rx_idle)          idle_cnt_reg <= idle_cnt_reg + 1'b1;

            if (rx_valid) begin
               case (fstate_reg)
                  FR_HUNT_DE: begin
                     if (rx_byte == FRAME_HDR0) fstate_reg <= FR_HUNT_AD;
                  end
                  FR_HUNT_AD: begin
                     if (rx_byte == FRAME_HDR1) begin
                        fstate_reg <= FR_PAYLOAD;
                        idx_reg    <= '0;
                     end else if (rx_byte != FRAME_HDR0) begin
                        fstate_reg <= FR_HUNT_DE;
                     end
                  end
                  default: begin
                     if (idx_reg == LAST_IDX) begin
                        fstate_reg      <= FR_HUNT_DE;
                        frame_valid_reg <= 1'b1;
                        roll_reg        <= be16(shadow_next[0], shadow_next[1]);
                        pitch_reg       <= be16(shadow_next[2], shadow_next[3]);
                        yaw_reg         <= be16(shadow_next[4], shadow_next[5]);
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomised and directed bench for uart_frame_rx with a byte-level frame model
// and a per-cycle compare process.
module tb_uart_frame_rx;

   localparam int BD  = 16;
   localparam int TOB = 20;

   localparam int TOK_ERR = 256;
   localparam int TOK_GAP = 257;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic [15:0] roll;
   logic [15:0] pitch;
   logic [15:0] yaw;
   logic        frame_valid;
   logic        frame_err;

   uart_frame_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TOB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .roll        (roll),
      .pitch       (pitch),
      .yaw         (yaw),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected events in order: byte values, TOK_ERR (bad stop bit), TOK_GAP
   // (long idle that must time out only if a frame is open).
   int tokq[$];
   logic [7:0] seq[$];

   int          m_prev = -1;
   bit          m_in_frame = 1'b0;
   logic [7:0]  m_pay[$];
   logic [15:0] m_roll = '0, m_pitch = '0, m_yaw = '0;
   logic [15:0] st_roll = '0, st_pitch = '0, st_yaw = '0;
   bit          fv_due = 1'b0;

   int n_bv = 0, n_fv = 0, n_fe = 0;

   function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function void model_hunt_reset();
      m_in_frame = 1'b0;
      m_prev     = -1;
      m_pay.delete();
   endfunction

   function void model_byte(input logic [7:0] b);
      if (m_in_frame) begin
         m_pay.push_back(b);
         if (m_pay.size() == 6) begin
            st_roll  = {m_pay[0], m_pay[1]};
            st_pitch = {m_pay[2], m_pay[3]};
            st_yaw   = {m_pay[4], m_pay[5]};
            fv_due   = 1'b1;
            model_hunt_reset();
         end
      end else if (m_prev == 32'hDE && b == 8'hAD) begin
         m_in_frame = 1'b1;
         m_pay.delete();
         m_prev = -1;
      end else begin
         m_prev = int'(b);
      end
   endfunction

   always @(negedge clk) begin : cmp
      bit exp_fv;
      bit ok;
      int t;
      if (!rst_n) begin
         chk("reset_outputs", {5'd0, byte_data, byte_valid, roll, pitch, yaw, frame_valid, frame_err}, 64'd0);
         model_hunt_reset();
         m_roll = '0; m_pitch = '0; m_yaw = '0;
         fv_due = 1'b0;
         tokq.delete();
      end else begin
         exp_fv = fv_due;
         if (fv_due) begin
            m_roll = st_roll; m_pitch = st_pitch; m_yaw = st_yaw;
            fv_due = 1'b0;
         end
         chk("frame_valid", {63'd0, frame_valid}, {63'd0, exp_fv});
         chk("angles", {16'd0, roll, pitch, yaw}, {16'd0, m_roll, m_pitch, m_yaw});
         chk("err_with_valid", {63'd0, frame_err & frame_valid}, 64'd0);
         if (frame_valid) begin
            n_fv++;
            $display("frame roll=%0d pitch=%0d yaw=%0d", $signed(roll), $signed(pitch), $signed(yaw));
         end
         while (tokq.size() > 0 && tokq[0] == TOK_GAP && !(m_in_frame || m_prev == 32'hDE))
            void'(tokq.pop_front());
         if (byte_valid) begin
            n_bv++;
            ok = (tokq.size() > 0) && (tokq[0] < 256);
            chk("byte_expected", {63'd0, ok}, 64'd1);
            if (ok) begin
               t = tokq.pop_front();
               chk("byte_data", {56'd0, byte_data}, {56'd0, t[7:0]});
               model_byte(t[7:0]);
            end
         end
         if (frame_err) begin
            n_fe++;
            $display("frame_err pulse");
            ok = (tokq.size() > 0) && (tokq[0] >= 256);
            chk("err_expected", {63'd0, ok}, 64'd1);
            if (ok) begin
               void'(tokq.pop_front());
               model_hunt_reset();
            end
         end
      end
   end

   task automatic bit_time(input logic v);
      rx = v;
      repeat (BD) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) bit_time(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      tokq.push_back(stop ? int'(b) : TOK_ERR);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      if (!stop) bit_time(1'b1);
   endtask

   task automatic send_seq(input int bad_idx, input int max_gap);
      for (int i = 0; i < seq.size(); i++) begin
         send_byte(seq[i], i != bad_idx);
         if (max_gap > 0) idle_bits(int'($urandom_range(max_gap, 0)));
      end
      idle_bits(2);
   endtask

   task automatic check_counts(input string name, input int bv0, input int fv0, input int fe0,
                               input int bv, input int fv, input int fe);
      chk({name, "_bytes"},  64'(n_bv - bv0), 64'(bv));
      chk({name, "_frames"}, 64'(n_fv - fv0), 64'(fv));
      chk({name, "_errs"},   64'(n_fe - fe0), 64'(fe));
   endtask

   task automatic check_angles(input string name, input logic [15:0] r, input logic [15:0] p,
                               input logic [15:0] y);
      chk({name, "_roll"},  {48'd0, roll},  {48'd0, r});
      chk({name, "_pitch"}, {48'd0, pitch}, {48'd0, p});
      chk({name, "_yaw"},   {48'd0, yaw},   {48'd0, y});
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bv0, fv0, fe0;
      logic [7:0] g;

      repeat (4) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      check_angles("reset", 16'h0000, 16'h0000, 16'h0000);
      chk("reset_flags", {61'd0, byte_valid, frame_valid, frame_err}, 64'd0);
      idle_bits(2);

      // Clean frame
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      seq = '{8'hDE, 8'hAD, 8'h12, 8'h34, 8'hFE, 8'hDC, 8'h00, 8'h80};
      send_seq(-1, 0);
      check_counts("clean", bv0, fv0, fe0, 8, 1, 0);
      check_angles("clean", 16'h1234, 16'hFEDC, 16'h0080);

      // Header resync
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      seq = '{8'h55, 8'hDE, 8'hDE, 8'hAD, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      send_seq(-1, 0);
      check_counts("resync", bv0, fv0, fe0, 10, 1, 0);
      check_angles("resync", 16'd1, 16'd2, 16'd3);

      // Framing error on byte 4, then a clean frame
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      seq = '{8'hDE, 8'hAD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_seq(4, 0);
      check_counts("framing", bv0, fv0, fe0, 7, 0, 1);
      check_angles("framing_hold", 16'd1, 16'd2, 16'd3);
      seq = '{8'hDE, 8'hAD, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h00, 8'h0C};
      send_seq(-1, 0);
      check_angles("after_err", 16'd10, 16'd11, 16'd12);

      // Timeout inside payload
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      seq = '{8'hDE, 8'hAD, 8'h11, 8'h22};
      for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
      tokq.push_back(TOK_GAP);
      idle_bits(21);
      seq = '{8'h33, 8'h44, 8'h55, 8'h66};
      send_seq(-1, 0);
      check_counts("timeout", bv0, fv0, fe0, 8, 0, 1);
      check_angles("timeout_hold", 16'd10, 16'd11, 16'd12);

      // Glitch
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      idle_bits(4);
      check_counts("glitch", bv0, fv0, fe0, 0, 0, 0);
      seq = '{8'hDE, 8'hAD, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
      send_seq(-1, 0);
      check_angles("post_glitch", 16'h0123, 16'h4567, 16'h89AB);

      // Reset in the middle of payload byte 3
      seq = '{8'hDE, 8'hAD, 8'h01, 8'h02};
      for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      @(posedge clk); #2 rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check_angles("midreset", 16'h0000, 16'h0000, 16'h0000);
      chk("midreset_byte", {56'd0, byte_data}, 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      idle_bits(3);
      seq = '{8'hDE, 8'hAD, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'h12, 8'h34};
      send_seq(-1, 0);
      check_angles("after_reset", 16'h7FFF, 16'h8000, 16'h1234);

      // Randomised frames with garbage prefixes and short inter-byte gaps
      bv0 = n_bv; fv0 = n_fv; fe0 = n_fe;
      for (int f = 0; f < 12; f++) begin
         seq.delete();
         for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
            g = 8'($urandom);
            if (g == 8'hDE) g = 8'h11;
            seq.push_back(g);
         end
         seq.push_back(8'hDE);
         seq.push_back(8'hAD);
         for (int k = 0; k < 6; k++) seq.push_back(8'($urandom));
         send_seq(-1, 2);
      end
      chk("random_frames", 64'(n_fv - fv0), 64'd12);
      chk("random_errs", 64'(n_fe - fe0), 64'd0);

      idle_bits(3);
      while (tokq.size() > 0 && tokq[0] == TOK_GAP && !(m_in_frame || m_prev == 32'hDE))
         void'(tokq.pop_front());
      chk("pending_events", 64'(tokq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
